counter_checker: RTL and testbench

COUNTER_CHECKER -- requirements
Module: counter_checker

---
 rtl/counter_checker.sv | 137 +++++++++++++
 tb/tb_counter_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
`default_nettype none
// ============================================================================
// Module  : counter_checker
// Brief   : Checks a loadable up-counter against a one-cycle-latency model and
//           reports overflow, load-during-increment and value mismatches.
// Rev     : 1.0
// ============================================================================
module counter_checker #(
    parameter int WIDTH      = 3,
    parameter int MAX_VALUE  = 2**WIDTH-1,
    parameter int ALLOW_WRAP = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 ld,
    input  logic                 inc,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [WIDTH-1:0]     data_out,
    input  logic                 clr_err,
    output logic                 error,
    output logic [2:0]           fire,
    output logic [2:0]           sticky,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 first_valid,
    output logic [1:0]           first_code
);

    localparam logic [WIDTH-1:0]     c_MAX_VAL = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0]     c_ONE     = WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     r_expected;
    logic                 r_model_valid;
    logic [2:0]           r_fire;
    logic                 r_error;
    logic [2:0]           r_sticky;
    logic [CNT_WIDTH-1:0] r_err_count;
    logic                 r_first_valid;
    logic [1:0]           r_first_code;

    logic                 w_overflow;
    logic                 w_ld_on_inc;
    logic                 w_mismatch;
    logic                 w_any;
    logic                 w_clr;
    logic [2:0]           w_rules;
    logic [1:0]           w_code;
    logic [WIDTH-1:0]     w_expected_next;
    logic [CNT_WIDTH-1:0] w_cnt_base;
    logic [CNT_WIDTH-1:0] w_cnt_next;

    assign w_overflow  = enable && inc && (data_out == c_MAX_VAL) && (ALLOW_WRAP == 0);
    assign w_ld_on_inc = enable && inc && ld;
    assign w_mismatch  = enable && r_model_valid && (data_out != r_expected);
    assign w_rules     = {w_mismatch, w_ld_on_inc, w_overflow};
    assign w_any       = |w_rules;
    // A disabled checker holds all state, including against clr_err.
    assign w_clr       = clr_err && enable;

    always_comb begin
        w_code = 2'b00;
        if (w_overflow) begin
            w_code = 2'b01;
        end else if (w_ld_on_inc) begin
            w_code = 2'b10;
        end else if (w_mismatch) begin
            w_code = 2'b11;
        end
    end

    always_comb begin
        w_expected_next = r_expected;
        if (ld) begin
            w_expected_next = data_in;
        end else if (inc) begin
            w_expected_next = (r_expected == c_MAX_VAL) ? '0 : r_expected + c_ONE;
        end
    end

    // Clear first, then count this edge's violation on top of the cleared value.
    always_comb begin
        w_cnt_base = w_clr ? '0 : r_err_count;
        w_cnt_next = w_cnt_base;
        if (w_any && (w_cnt_base != '1)) begin
            w_cnt_next = w_cnt_base + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expected    <= '0;
            r_model_valid <= 1'b0;
            r_fire        <= '0;
            r_error       <= 1'b0;
        end else if (enable) begin
            r_expected <= w_expected_next;
            r_fire     <= w_rules;
            r_error    <= w_any;
            if (ld) begin
                r_model_valid <= 1'b1;
            end
        end else begin
            r_fire  <= '0;
            r_error <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky      <= '0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_code  <= 2'b00;
        end else begin
            r_sticky    <= (w_clr ? 3'b000 : r_sticky) | w_rules;
            r_err_count <= w_cnt_next;
            if (w_clr) begin
                r_first_valid <= w_any;
                r_first_code  <= w_code;
            end else if (!r_first_valid && w_any) begin
                r_first_valid <= 1'b1;
                r_first_code  <= w_code;
            end
        end
    end

    assign error       = r_error;
    assign fire        = r_fire;
    assign sticky      = r_sticky;
    assign err_count   = r_err_count;
    assign first_valid = r_first_valid;
    assign first_code  = r_first_code;

endmodule
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_counter_checker
// Brief   : Self-checking bench: three checker configurations against a
//           behavioural model, directed scenarios followed by random traffic.
// Rev     : 1.0
// ============================================================================
module tb_counter_checker;

    localparam int c_N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       ld = 1'b0;
    logic       inc = 1'b0;
    logic [2:0] data_in = '0;
    logic [2:0] data_out = '0;
    logic       clr_err = 1'b0;

    logic       err_o    [c_N];
    logic [2:0] fire_o   [c_N];
    logic [2:0] sticky_o [c_N];
    logic [7:0] cnt_o    [c_N];
    logic       fv_o     [c_N];
    logic [1:0] fc_o     [c_N];
    logic [1:0] cnt_small;

    int compared   = 0;
    int mismatched = 0;

    // Model configuration and state, one entry per DUT instance.
    int         maxv_m   [c_N] = '{7, 5, 7};
    bit         wrap_m   [c_N] = '{0, 1, 0};
    int         cntmax_m [c_N] = '{255, 255, 3};
    int         exp_m    [c_N];
    bit         mv_m     [c_N];
    logic [2:0] fire_m   [c_N];
    logic [2:0] sticky_m [c_N];
    int         cnt_m    [c_N];
    bit         fv_m     [c_N];
    logic [1:0] fc_m     [c_N];

    always #5 clk = ~clk;

    counter_checker u_dflt (
        .clk(clk), .rst(rst), .enable(enable), .ld(ld), .inc(inc),
        .data_in(data_in), .data_out(data_out), .clr_err(clr_err),
        .error(err_o[0]), .fire(fire_o[0]), .sticky(sticky_o[0]),
        .err_count(cnt_o[0]), .first_valid(fv_o[0]), .first_code(fc_o[0])
    );

    counter_checker #(.WIDTH(3), .MAX_VALUE(5), .ALLOW_WRAP(1), .CNT_WIDTH(8)) u_wrap (
        .clk(clk), .rst(rst), .enable(enable), .ld(ld), .inc(inc),
        .data_in(data_in), .data_out(data_out), .clr_err(clr_err),
        .error(err_o[1]), .fire(fire_o[1]), .sticky(sticky_o[1]),
        .err_count(cnt_o[1]), .first_valid(fv_o[1]), .first_code(fc_o[1])
    );

    counter_checker #(.WIDTH(3), .CNT_WIDTH(2)) u_cnt2 (
        .clk(clk), .rst(rst), .enable(enable), .ld(ld), .inc(inc),
        .data_in(data_in), .data_out(data_out), .clr_err(clr_err),
        .error(err_o[2]), .fire(fire_o[2]), .sticky(sticky_o[2]),
        .err_count(cnt_small), .first_valid(fv_o[2]), .first_code(fc_o[2])
    );

    assign cnt_o[2] = {6'b000000, cnt_small};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < c_N; k++) begin
            exp_m[k] = 0; mv_m[k] = 0; fire_m[k] = '0; sticky_m[k] = '0;
            cnt_m[k] = 0; fv_m[k] = 0; fc_m[k] = 2'b00;
        end
    endtask

    // One enabled/disabled clock edge of the checker, from the rules as written.
    task automatic model_edge();
        bit ov, li, mm;
        for (int k = 0; k < c_N; k++) begin
            if (!enable) begin
                fire_m[k] = '0;
                continue;
            end
            ov = inc && (int'(data_out) == maxv_m[k]) && !wrap_m[k];
            li = inc && ld;
            mm = mv_m[k] && (int'(data_out) != exp_m[k]);
            fire_m[k] = {mm, li, ov};
            if (clr_err) begin
                sticky_m[k] = '0; cnt_m[k] = 0; fv_m[k] = 0; fc_m[k] = 2'b00;
            end
            sticky_m[k] |= fire_m[k];
            if (ov || li || mm) begin
                if (cnt_m[k] < cntmax_m[k]) cnt_m[k]++;
                if (!fv_m[k]) begin
                    fv_m[k] = 1;
                    fc_m[k] = ov ? 2'b01 : (li ? 2'b10 : 2'b11);
                end
            end
            if (ld) begin
                exp_m[k] = int'(data_in);
                mv_m[k]  = 1;
            end else if (inc) begin
                exp_m[k] = (exp_m[k] == maxv_m[k]) ? 0 : (exp_m[k] + 1) % 8;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < c_N; k++) begin
            chk($sformatf("%s.i%0d.error", tag, k), 32'(err_o[k]), 32'(|fire_m[k]));
            chk($sformatf("%s.i%0d.fire", tag, k), 32'(fire_o[k]), 32'(fire_m[k]));
            chk($sformatf("%s.i%0d.sticky", tag, k), 32'(sticky_o[k]), 32'(sticky_m[k]));
            chk($sformatf("%s.i%0d.err_count", tag, k), 32'(cnt_o[k]), 32'(cnt_m[k]));
            chk($sformatf("%s.i%0d.first_valid", tag, k), 32'(fv_o[k]), 32'(fv_m[k]));
            chk($sformatf("%s.i%0d.first_code", tag, k), 32'(fc_o[k]), 32'(fc_m[k]));
        end
    endtask

    task automatic step(input string tag, input bit s_en, input bit s_ld, input bit s_inc,
                        input int s_din, input int s_dout, input bit s_clr);
        enable = s_en; ld = s_ld; inc = s_inc; clr_err = s_clr;
        data_in = 3'(s_din); data_out = 3'(s_dout);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Reset pulse placed strictly between clock edges.
    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        int dout;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Load 5, count up to the terminal value, then increment past it.
        step("ld5",    1, 1, 0, 5, 0, 0);
        step("inc5",   1, 0, 1, 0, 5, 0);
        step("inc6",   1, 0, 1, 0, 6, 0);
        chk("wrap_mismatch_fire", 32'(fire_o[1]), 32'(3'b100));
        step("hold7",  1, 0, 0, 0, 7, 0);
        chk("no_fire_before_ovf", 32'(fire_o[0]), 32'(3'b000));
        step("ovf7",   1, 0, 1, 0, 7, 0);
        chk("ovf_fire", 32'(fire_o[0]), 32'(3'b001));
        chk("ovf_first_code", 32'(fc_o[0]), 32'(2'b01));

        // Load and increment together; ld wins in the model.
        step("ldinc",  1, 1, 1, 3, 0, 0);
        chk("ldinc_fire", 32'(fire_o[0]), 32'(3'b010));
        chk("ldinc_count", 32'(cnt_o[0]), 32'd2);
        step("ld_took", 1, 0, 0, 0, 3, 0);
        chk("ld_priority_no_mm", 32'(fire_o[0]), 32'(3'b000));

        // Counter stuck while incrementing.
        step("ld2",    1, 1, 0, 2, 3, 0);
        step("inc2",   1, 0, 1, 0, 2, 0);
        step("stuck2", 1, 0, 1, 0, 2, 0);
        chk("stuck_fire", 32'(fire_o[0]), 32'(3'b100));

        // Saturate the narrow counter, then clear alongside a new violation.
        step("sat_a",  1, 1, 1, 0, 2, 0);
        step("sat_b",  1, 1, 1, 4, 5, 0);
        chk("sat_count", 32'(cnt_o[2]), 32'd3);
        step("clr_li", 1, 1, 1, 1, 4, 1);
        chk("clr_count", 32'(cnt_o[2]), 32'd1);
        chk("clr_sticky", 32'(sticky_o[2]), 32'(3'b010));
        chk("clr_first_code", 32'(fc_o[2]), 32'(2'b10));

        // Disabled cycle: would violate everything, but must freeze.
        step("dis",    0, 1, 1, 6, 7, 0);
        chk("dis_fire", 32'(fire_o[0]), 32'(3'b000));
        step("dis_rel", 1, 0, 0, 0, 1, 0);

        // Asynchronous reset after violations, then increment with no model.
        step("pre_rst", 1, 0, 1, 0, 7, 0);
        mid_reset("async_rst");
        step("inc_nold", 1, 0, 1, 0, 3, 0);
        chk("no_mm_after_rst", 32'(fire_o[0]), 32'(3'b000));

        // Random traffic, data_out usually tracking the default model.
        for (int n = 0; n < 400; n++) begin
            bit r_en, r_clr;
            r_en  = ($urandom_range(7) != 0);
            r_clr = r_en && ($urandom_range(15) == 0);
            dout  = ($urandom_range(1) == 0) ? exp_m[0] : int'($urandom_range(7));
            step($sformatf("rnd%0d", n), r_en, ($urandom_range(7) == 0),
                 ($urandom_range(1) == 1), int'($urandom_range(7)), dout, r_clr);
            if ($urandom_range(63) == 0) mid_reset($sformatf("rnd_rst%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
